// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 8-bit video RAM bank (two paralleled 1024x4 SRAMs)
// between the video scan-out fetcher and the CPU bus. Each grant runs a
// fixed read sequence or a setup/strobe/hold write pulse on the RAM pins.
// Optional feature: define VRAM_ARB_FAIR_EN for round-robin arbitration.
// Without it, video has strict priority.

module vram_arbiter #(
    parameter int unsigned WR_STROBE = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vid_req_i,
    input  logic [9:0] vid_addr_i,
    output logic       vid_ack_o,
    output logic [7:0] vid_data_o,
    input  logic       cpu_req_i,
    input  logic       cpu_we_i,
    input  logic [9:0] cpu_addr_i,
    input  logic [7:0] cpu_wdata_i,
    output logic [7:0] cpu_rdata_o,
    output logic       cpu_ack_o,
    output logic       cpu_wait_o,
    output logic       ram_cs_n_o,
    output logic       ram_we_n_o,
    output logic [9:0] ram_addr_o,
    output logic [7:0] ram_dout_o,
    output logic       ram_doe_o,
    input  logic [7:0] ram_din_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_SAMPLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD
    } state_t;

    // The strobe counter counts down to zero, so it is loaded with length-1.
    localparam logic [2:0] STROBE_LOAD = 3'(WR_STROBE - 1);

    state_t     state_q, state_d;
    logic       owner_cpu_q, owner_cpu_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] vid_data_q, cpu_rdata_q;
    logic       grant_vid, grant_cpu;
    logic       cpu_ack;

`ifdef VRAM_ARB_FAIR_EN
    logic last_cpu_q;

    // On a tie, grant the side that was not served last.
    always_comb begin
        grant_cpu = cpu_req_i & (~vid_req_i | ~last_cpu_q);
        grant_vid = vid_req_i & ~grant_cpu;
    end

    // Track who won the most recent grant; after reset video counts as served last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_cpu_q <= 1'b0;
        end else if (state_q == S_IDLE && (grant_vid || grant_cpu)) begin
            last_cpu_q <= grant_cpu;
        end
    end
`else
    // Strict priority: a pending video fetch always beats the CPU.
    always_comb begin
        grant_vid = vid_req_i;
        grant_cpu = cpu_req_i & ~vid_req_i;
    end
`endif

    // Next-state sequencing plus the RAM pin waveforms decoded from the current state.
    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        ram_cs_n_o  = 1'b1;
        ram_we_n_o  = 1'b1;
        ram_doe_o   = 1'b0;
        vid_ack_o   = 1'b0;
        cpu_ack     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vid) begin
                    owner_cpu_d = 1'b0;
                    addr_d      = vid_addr_i;
                    state_d     = S_RD_ADDR;
                end else if (grant_cpu) begin
                    owner_cpu_d = 1'b1;
                    addr_d      = cpu_addr_i;
                    if (cpu_we_i) begin
                        data_d  = cpu_wdata_i;
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                ram_cs_n_o = 1'b0;
                state_d    = S_RD_SAMPLE;
            end
            S_RD_SAMPLE: begin
                ram_cs_n_o = 1'b0;
                vid_ack_o  = ~owner_cpu_q;
                cpu_ack    = owner_cpu_q;
                state_d    = S_IDLE;
            end
            S_WR_SETUP: begin
                ram_cs_n_o = 1'b0;
                ram_doe_o  = 1'b1;
                cnt_d      = STROBE_LOAD;
                state_d    = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                ram_cs_n_o = 1'b0;
                ram_we_n_o = 1'b0;
                ram_doe_o  = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WR_HOLD: begin
                ram_cs_n_o = 1'b0;
                ram_doe_o  = 1'b1;
                cpu_ack    = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched transaction and read-data registers; reset forces the pins idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_cpu_q <= 1'b0;
            addr_q      <= 10'd0;
            data_q      <= 8'h00;
            cnt_q       <= 3'd0;
            vid_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            if (state_q == S_RD_SAMPLE) begin
                if (owner_cpu_q) begin
                    cpu_rdata_q <= ram_din_i;
                end else begin
                    vid_data_q <= ram_din_i;
                end
            end
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_dout_o  = data_q;
    assign vid_data_o  = vid_data_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack;
    assign cpu_wait_o  = cpu_req_i & ~cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed bench for vram_arbiter with a
// transaction-level reference model and a behavioural model of the SRAM chips.
// Build with VRAM_ARB_FAIR_EN defined to exercise round-robin arbitration.

module tb_vram_arbiter;

    localparam int WRS = 2;

    logic       clk;
    logic       rst;
    logic       vidReq;
    logic [9:0] vidAddr;
    logic       vidAck;
    logic [7:0] vidData;
    logic       cpuReq;
    logic       cpuWe;
    logic [9:0] cpuAddr;
    logic [7:0] cpuWdata;
    logic [7:0] cpuRdata;
    logic       cpuAck;
    logic       cpuWait;
    logic       ramCsN;
    logic       ramWeN;
    logic [9:0] ramAddr;
    logic [7:0] ramDout;
    logic       ramDoe;
    logic [7:0] ramDin;

    logic       sw1Req, sw7Req;
    logic [9:0] swAddr;
    logic [7:0] swData;
    logic       s1VidAck, s1CpuAck, s1CpuWait, s1CsN, s1WeN, s1Doe;
    logic [7:0] s1VidData, s1CpuRdata, s1Dout;
    logic [9:0] s1Addr;
    logic       s7VidAck, s7CpuAck, s7CpuWait, s7CsN, s7WeN, s7Doe;
    logic [7:0] s7VidData, s7CpuRdata, s7Dout;
    logic [9:0] s7Addr;

    logic [7:0] chipMem [0:1023];
    logic [7:0] expMem  [0:1023];

    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;

    vram_arbiter #(.WR_STROBE(WRS)) dut (
        .clk_i(clk), .rst_i(rst),
        .vid_req_i(vidReq), .vid_addr_i(vidAddr), .vid_ack_o(vidAck), .vid_data_o(vidData),
        .cpu_req_i(cpuReq), .cpu_we_i(cpuWe), .cpu_addr_i(cpuAddr), .cpu_wdata_i(cpuWdata),
        .cpu_rdata_o(cpuRdata), .cpu_ack_o(cpuAck), .cpu_wait_o(cpuWait),
        .ram_cs_n_o(ramCsN), .ram_we_n_o(ramWeN), .ram_addr_o(ramAddr),
        .ram_dout_o(ramDout), .ram_doe_o(ramDoe), .ram_din_i(ramDin)
    );

    vram_arbiter #(.WR_STROBE(1)) dutS1 (
        .clk_i(clk), .rst_i(rst),
        .vid_req_i(1'b0), .vid_addr_i(10'd0), .vid_ack_o(s1VidAck), .vid_data_o(s1VidData),
        .cpu_req_i(sw1Req), .cpu_we_i(1'b1), .cpu_addr_i(swAddr), .cpu_wdata_i(swData),
        .cpu_rdata_o(s1CpuRdata), .cpu_ack_o(s1CpuAck), .cpu_wait_o(s1CpuWait),
        .ram_cs_n_o(s1CsN), .ram_we_n_o(s1WeN), .ram_addr_o(s1Addr),
        .ram_dout_o(s1Dout), .ram_doe_o(s1Doe), .ram_din_i(8'h00)
    );

    vram_arbiter #(.WR_STROBE(7)) dutS7 (
        .clk_i(clk), .rst_i(rst),
        .vid_req_i(1'b0), .vid_addr_i(10'd0), .vid_ack_o(s7VidAck), .vid_data_o(s7VidData),
        .cpu_req_i(sw7Req), .cpu_we_i(1'b1), .cpu_addr_i(swAddr), .cpu_wdata_i(swData),
        .cpu_rdata_o(s7CpuRdata), .cpu_ack_o(s7CpuAck), .cpu_wait_o(s7CpuWait),
        .ram_cs_n_o(s7CsN), .ram_we_n_o(s7WeN), .ram_addr_o(s7Addr),
        .ram_dout_o(s7Dout), .ram_doe_o(s7Doe), .ram_din_i(8'h00)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write latched mid-cycle while strobed.
    assign ramDin = chipMem[ramAddr];
    always @(negedge clk) begin
        if (ramCsN === 1'b0 && ramWeN === 1'b0) chipMem[ramAddr] = ramDout;
    end

    // Requester and reference-model state.
    bit         vidPend, cpuPend, dropVid, dropCpu, vidSat;
    bit         newVid, newCpu, newCpuWe;
    logic [9:0] newVidAddr, newCpuAddr;
    logic [7:0] newCpuData;
    bit         mBusy, mOwnerCpu, mWe, mLastCpu;
    logic [9:0] mAddr;
    logic [7:0] mData;
    int         mGrant, mAck;
    logic [7:0] expVidData, expCpuData;
    int         lastVidAck, lastCpuAck, weLowCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [9:0] pickAddr();
        case ($urandom_range(7))
            0: return 10'h000;
            1: return 10'h001;
            2: return 10'h010;
            3: return 10'h020;
            4: return 10'h155;
            5: return 10'h2AA;
            6: return 10'h3FE;
            default: return 10'h3FF;
        endcase
    endfunction

    // One clock cycle: drive requests, predict every pin from the transaction model, compare.
    task automatic applyStimulus();
        int   phase;
        bit   takeCpu;
        logic expCs, expWe, expDoe, expVAck, expCAck;
        @(posedge clk);
        #1;
        cyc++;
        if (dropVid) begin
            vidPend = vidSat;
            if (vidSat) vidAddr = pickAddr();
        end
        if (dropCpu) cpuPend = 1'b0;
        dropVid = 1'b0;
        dropCpu = 1'b0;
        if (newVid && !vidPend) begin
            vidPend = 1'b1;
            vidAddr = newVidAddr;
        end
        if (newCpu && !cpuPend) begin
            cpuPend  = 1'b1;
            cpuWe    = newCpuWe;
            cpuAddr  = newCpuAddr;
            cpuWdata = newCpuData;
        end
        newVid = 1'b0;
        newCpu = 1'b0;
        vidReq = vidPend;
        cpuReq = cpuPend;

        if (!rst && !mBusy && (vidPend || cpuPend)) begin
`ifdef VRAM_ARB_FAIR_EN
            takeCpu = cpuPend && (!vidPend || !mLastCpu);
`else
            takeCpu = cpuPend && !vidPend;
`endif
            mBusy     = 1'b1;
            mOwnerCpu = takeCpu;
            mWe       = takeCpu && cpuWe;
            mAddr     = takeCpu ? cpuAddr : vidAddr;
            mData     = cpuWdata;
            mGrant    = cyc;
            mAck      = cyc + (mWe ? WRS + 2 : 2);
            mLastCpu  = takeCpu;
        end

        phase   = cyc - mGrant;
        expCs   = !(mBusy && phase >= 1);
        expWe   = !(mBusy && mWe && phase >= 2 && phase <= WRS + 1);
        expDoe  = mBusy && mWe && phase >= 1;
        expVAck = mBusy && !mOwnerCpu && cyc == mAck;
        expCAck = mBusy && mOwnerCpu && cyc == mAck;

        #1;
        checkOutput("ram_cs_n", ramCsN, expCs);
        checkOutput("ram_we_n", ramWeN, expWe);
        checkOutput("ram_doe", ramDoe, expDoe);
        checkOutput("vid_ack", vidAck, expVAck);
        checkOutput("cpu_ack", cpuAck, expCAck);
        checkOutput("cpu_wait", cpuWait, cpuPend && !expCAck);
        checkOutput("vid_data", vidData, expVidData);
        checkOutput("cpu_rdata", cpuRdata, expCpuData);
        if (mBusy && phase >= 1) checkOutput("ram_addr", ramAddr, mAddr);
        if (mBusy && mWe && phase >= 1) checkOutput("ram_dout", ramDout, mData);

        if (vidAck === 1'b1) lastVidAck = cyc;
        if (cpuAck === 1'b1) lastCpuAck = cyc;
        if (ramWeN === 1'b0) weLowCount++;

        if (mBusy && cyc == mAck) begin
            mBusy = 1'b0;
            if (mOwnerCpu) begin
                dropCpu = 1'b1;
                if (mWe) expMem[mAddr] = mData;
                else     expCpuData = expMem[mAddr];
            end else begin
                dropVid    = 1'b1;
                expVidData = expMem[mAddr];
            end
        end
    endtask

    task automatic cpuRequest(input bit we, input logic [9:0] a, input logic [7:0] d);
        newCpu     = 1'b1;
        newCpuWe   = we;
        newCpuAddr = a;
        newCpuData = d;
    endtask

    // Strobe-length sweep on the WR_STROBE=1 and WR_STROBE=7 instances.
    task automatic sweepRun();
        int         lowCnt [2];
        int         ackCyc [2];
        logic [9:0] a;
        logic [7:0] d;
        a = 10'h2C7;
        d = 8'h96;
        lowCnt[0] = 0; lowCnt[1] = 0;
        ackCyc[0] = -1; ackCyc[1] = -1;
        @(posedge clk);
        #1;
        swAddr = a;
        swData = d;
        sw1Req = 1'b1;
        sw7Req = 1'b1;
        for (int t = 0; t < 16; t++) begin
            #1;
            if (s1WeN === 1'b0) begin
                lowCnt[0]++;
                checkOutput("sw1_addr", s1Addr, a);
                checkOutput("sw1_dout", s1Dout, d);
            end
            if (s7WeN === 1'b0) begin
                lowCnt[1]++;
                checkOutput("sw7_addr", s7Addr, a);
                checkOutput("sw7_dout", s7Dout, d);
            end
            if (s1CpuAck === 1'b1) begin
                ackCyc[0] = t;
                checkOutput("sw1_ack_in_hold", {s1CsN, s1WeN, s1Doe}, 3'b011);
            end
            if (s7CpuAck === 1'b1) begin
                ackCyc[1] = t;
                checkOutput("sw7_ack_in_hold", {s7CsN, s7WeN, s7Doe}, 3'b011);
            end
            @(posedge clk);
            #1;
            if (ackCyc[0] == t) sw1Req = 1'b0;
            if (ackCyc[1] == t) sw7Req = 1'b0;
        end
        checkOutput("sw1_low_width", lowCnt[0], 1);
        checkOutput("sw1_ack_latency", ackCyc[0], 3);
        checkOutput("sw7_low_width", lowCnt[1], 7);
        checkOutput("sw7_ack_latency", ackCyc[1], 9);
    endtask

    initial begin
        int rdRaise;
        int cpuRaise;
        int waitHigh;

        for (int i = 0; i < 1024; i++) begin
            chipMem[i] = 8'($urandom);
            expMem[i]  = chipMem[i];
        end
        rst = 1'b1;
        vidReq = 1'b0; vidAddr = 10'd0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 10'd0; cpuWdata = 8'h00;
        sw1Req = 1'b0; sw7Req = 1'b0; swAddr = 10'd0; swData = 8'h00;
        expVidData = 8'h00; expCpuData = 8'h00;
        lastVidAck = -1; lastCpuAck = -1; weLowCount = 0;

        // Reset values while reset is held.
        #3;
        checkOutput("rst_cs_n", ramCsN, 1'b1);
        checkOutput("rst_we_n", ramWeN, 1'b1);
        checkOutput("rst_doe", ramDoe, 1'b0);
        checkOutput("rst_addr", ramAddr, 10'd0);
        checkOutput("rst_dout", ramDout, 8'h00);
        checkOutput("rst_vid_ack", vidAck, 1'b0);
        checkOutput("rst_cpu_ack", cpuAck, 1'b0);
        checkOutput("rst_vid_data", vidData, 8'h00);
        checkOutput("rst_cpu_rdata", cpuRdata, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) applyStimulus();

        // Simultaneous video and CPU read requests.
        newVid = 1'b1;
        newVidAddr = 10'h010;
        cpuRequest(1'b0, 10'h020, 8'h00);
        repeat (10) applyStimulus();
        checkOutput("tie_vid_acked", lastVidAck >= 0, 1'b1);
        checkOutput("tie_cpu_acked", lastCpuAck >= 0, 1'b1);
`ifdef VRAM_ARB_FAIR_EN
        checkOutput("tie_cpu_first", lastCpuAck < lastVidAck, 1'b1);
`else
        checkOutput("tie_vid_first", lastVidAck < lastCpuAck, 1'b1);
`endif

        // CPU writes 0xA5 to 0x3FF, then reads it back.
        weLowCount = 0;
        cpuRequest(1'b1, 10'h3FF, 8'hA5);
        repeat (WRS + 5) applyStimulus();
        checkOutput("wr_strobe_width", weLowCount, WRS);
        lastCpuAck = -1;
        rdRaise = cyc + 1;
        cpuRequest(1'b0, 10'h3FF, 8'h00);
        repeat (5) applyStimulus();
        checkOutput("rd_ack_latency", lastCpuAck - rdRaise, 2);
        checkOutput("rd_data_a5", cpuRdata, 8'hA5);

        // Video saturation with a pending CPU read.
        vidSat = 1'b1;
        newVid = 1'b1;
        newVidAddr = pickAddr();
        applyStimulus();
        lastCpuAck = -1;
        cpuRaise = cyc + 1;
        cpuRequest(1'b0, 10'h155, 8'h00);
        waitHigh = 0;
        repeat (20) begin
            applyStimulus();
            if (cpuWait === 1'b1) waitHigh++;
        end
`ifdef VRAM_ARB_FAIR_EN
        checkOutput("sat_cpu_served", (lastCpuAck >= 0) && (lastCpuAck - cpuRaise < 8), 1'b1);
`else
        checkOutput("sat_cpu_wait_high", waitHigh, 20);
        checkOutput("sat_cpu_starved", lastCpuAck, -1);
`endif
        vidSat = 1'b0;
        repeat (12) applyStimulus();

        // Randomized traffic from both requesters.
        repeat (400) begin
            if (!vidPend && $urandom_range(3) == 0) begin
                newVid = 1'b1;
                newVidAddr = pickAddr();
            end
            if (!cpuPend && $urandom_range(2) == 0) begin
                cpuRequest(1'($urandom_range(1)), pickAddr(), 8'($urandom));
            end
            applyStimulus();
        end
        repeat (12) applyStimulus();

        // Reset asserted in the middle of the write strobe.
        cpuRequest(1'b1, 10'h0AA, 8'h5A);
        repeat (3) applyStimulus();
        checkOutput("pre_rst_we_n", ramWeN, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_we_n", ramWeN, 1'b1);
        checkOutput("midrst_doe", ramDoe, 1'b0);
        checkOutput("midrst_cs_n", ramCsN, 1'b1);
        checkOutput("midrst_cpu_ack", cpuAck, 1'b0);
        mBusy = 1'b0;
        mLastCpu = 1'b0;
        dropCpu = 1'b1;
        expVidData = 8'h00;
        expCpuData = 8'h00;
        expMem[10'h0AA] = chipMem[10'h0AA];
        repeat (3) applyStimulus();
        rst = 1'b0;
        repeat (4) applyStimulus();

        // Recovery after the aborted write.
        cpuRequest(1'b1, 10'h0AA, 8'h3C);
        repeat (WRS + 5) applyStimulus();
        cpuRequest(1'b0, 10'h0AA, 8'h00);
        repeat (5) applyStimulus();
        checkOutput("post_rst_rdata", cpuRdata, 8'h3C);

        sweepRun();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Sequencing controller that shares one bank of two paralleled 1024x4 static RAMs (an 8-bit-wide video RAM) between the video scan-out fetcher and the CPU bus. It converts each requester's request/acknowledge transaction into correctly ordered chip-select, write-enable, address and data waveforms on the RAM pins. Reads are sampled at a fixed latency, and writes are generated as a clean setup/strobe/hold pulse. It sits between the CPU address decoder and video timing logic on one side and the RAM chips plus their bidirectional data buffer on the other.

## Interface
- WR_STROBE, 2: number of clk cycles ram_we_n is held low during a write (legal range 1-7).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request; held high with vid_addr stable until vid_ack.
- vid_addr  in  10  video read address.
- vid_ack  out  1  one-cycle pulse; vid_data is valid from this cycle onward.
- vid_data  out  8  registered video read data; holds its value until the next video read.
- cpu_req  in  1  CPU request; held high with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  10  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered CPU read data; holds its value until the next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait  out  1  combinational `cpu_req & ~cpu_ack`; drives the CPU wait-state logic.
- ram_cs_n  out  1  RAM chip select, active low.
- ram_we_n  out  1  RAM write enable, active low.
- ram_addr  out  10  RAM address.
- ram_dout  out  8  data driven toward the RAM.
- ram_doe  out  1  enables the external tristate driver for ram_dout.
- ram_din  in  8  data read from the RAM.

## Operation
- States: IDLE, RD_ADDR, RD_SAMPLE, WR_SETUP, WR_STROBE, WR_HOLD.
- IDLE: grant one pending requester, latch its address and data, and drive ram_addr from the latch.
  - Read grant -> RD_ADDR.
  - Write grant -> WR_SETUP.
  - No request -> remain in IDLE.
- RD_ADDR:
  - ram_cs_n=0, ram_we_n=1, ram_doe=0.
  - Next state is RD_SAMPLE.
- RD_SAMPLE:
  - ram_cs_n=0.
  - At the end of the cycle, capture ram_din into vid_data or cpu_rdata.
  - Pulse the granted ack in the same cycle.
  - Next state is IDLE.
- WR_SETUP: ram_cs_n=0, ram_we_n=1, ram_doe=1, ram_dout=latched data; lasts 1 cycle.
- WR_STROBE: ram_we_n=0; lasts WR_STROBE cycles, counted by a 3-bit down-counter.
- WR_HOLD:
  - ram_we_n=1 while ram_cs_n, ram_doe and data are held; lasts 1 cycle.
  - cpu_ack pulses in this cycle, then the state returns to IDLE.
- Waveform guarantees:
  - ram_addr and ram_dout never change while ram_we_n=0.
  - ram_we_n never falls in the same cycle that ram_addr changes.
- The video port is read-only; it has no write path.
- Default arbitration: when both requesters are pending in IDLE, video wins.
- Requests are level-sensitive.
  - A req still high in IDLE after its ack is treated as a new request.
  - Requesters drop req on the edge where they see ack.
- cpu_wait is high for every cycle of a pending CPU transaction except the cycle in which cpu_ack pulses.

## Timing
- Reset values:
  - state=IDLE.
  - ram_cs_n=1, ram_we_n=1, ram_doe=0.
  - ram_addr=0, ram_dout=0.
  - vid_ack=0, cpu_ack=0.
  - vid_data=0x00, cpu_rdata=0x00.
- Read latency, counted from the IDLE grant cycle: ack arrives 2 cycles after grant (grant, RD_ADDR, RD_SAMPLE), so one read occupies 3 cycles.
- Write occupancy: grant + SETUP + WR_STROBE + HOLD = 5 cycles at the default WR_STROBE=2.
- Back-to-back accesses: every access passes through at least one IDLE cycle, and ram_cs_n returns to 1 in that cycle.
- Reset asserted mid-write: ram_we_n goes to 1 and ram_doe goes to 0 asynchronously.
  - The contents of the targeted location are undefined.
  - No ack is issued for the aborted transaction.
- A request that drops before its ack must not occur. If it does, the transaction already started completes, and its ack is still pulsed.

## Configuration
- VRAM_ARB_FAIR_EN defined:
  - Round-robin arbitration between the two requesters.
  - When both are pending in IDLE, the requester not served last wins.
  - After reset, video counts as served last, so the CPU wins the first tie.
- VRAM_ARB_FAIR_EN undefined:
  - Strict video priority.
  - A continuously requesting video port can stall the CPU indefinitely.

## Test plan
- Reset then idle:
  - Stimulus: hold rst=1, then release it with no requests.
  - Required: all outputs stay at their reset values, and ram_cs_n stays 1 indefinitely.
- CPU write then read:
  - Stimulus: CPU writes 0xA5 to 0x3FF, then reads 0x3FF.
  - Required: ram_we_n is low for exactly 2 cycles with ram_addr=0x3FF and ram_dout=0xA5 stable; the read returns cpu_rdata=0xA5 with cpu_ack 2 cycles after its grant.
- Simultaneous video and CPU requests:
  - Stimulus: vid_req (0x010) and cpu_req (read 0x020) rise in the same cycle.
  - Required without the macro: vid_ack comes first, then cpu_ack.
  - Required with VRAM_ARB_FAIR_EN, on the first tie after reset: cpu_ack comes first.
- Continuous video saturation:
  - Stimulus: vid_req is held high continuously while a CPU read is pending.
  - Required with the macro: the CPU completes within 8 cycles.
  - Required without the macro: cpu_wait stays high throughout.
- Reset during write:
  - Stimulus: assert rst during the WR_STROBE state.
  - Required: ram_we_n=1 and ram_doe=0 in the same cycle, and no cpu_ack is issued.
- Strobe-length sweep:
  - Stimulus: WR_STROBE=1 and WR_STROBE=7.
  - Required: the ram_we_n low width equals WR_STROBE cycles, and cpu_ack lands in WR_HOLD.
